// File: rtl/fpmult_pkg.sv
// Shared types for the FP-multiply mantissa-sharing logic.
// Tag IDs are sized for the largest supported requester count (4).
package fpmult_pkg;

    localparam int MW_DEF = 24;
    localparam int ID_W   = 2;

    function automatic int req_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpmult_rr_pick.sv
// Rotating-priority picker: one-hot grant to the first requester above ptr_i (mod NREQ).
// Purely combinational.
module fpmult_rr_pick
    import fpmult_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        // Offset k=1 is the requester just after the last winner; k=NREQ revisits the winner.
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_i[i] && (i == ((int'(ptr_i) + k) % NREQ))) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpmult_mant_arbiter.sv
// Round-robin scheduler sharing one pipelined mantissa multiplier between NREQ front ends;
// requester IDs ride a tag pipe in lockstep with the core and steer products back.
module fpmult_mant_arbiter
    import fpmult_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int MW   = MW_DEF,
    parameter int LAT  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*MW-1:0] req_ma,
    input  logic [NREQ*MW-1:0] req_mb,
    output logic [MW-1:0]      mul_ma,
    output logic [MW-1:0]      mul_mb,
    output logic               mul_en,
    input  logic [2*MW-1:0]    mul_mp,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [2*MW-1:0]    rsp_mp,
    output logic               busy
);

    // Stage 0 shadows the operand register; the remaining LAT stages shadow the core.
    localparam int NST = LAT + 1;

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [MW-1:0]   ma_q, ma_d, mb_q, mb_d;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] hs;
    tag_t            tag_d;
    tag_t            tag_q [NST];

    fpmult_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    assign req_ready = hold ? '0 : pick;
    assign hs        = req_valid & req_ready;
    assign mul_en    = ~hold;
    assign mul_ma    = ma_q;
    assign mul_mb    = mb_q;
    assign rsp_mp    = mul_mp;

    always_comb begin
        tag_d = '0;
        ptr_d = ptr_q;
        ma_d  = ma_q;
        mb_d  = mb_q;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                tag_d.v  = 1'b1;
                tag_d.id = ID_W'(i);
                ptr_d    = ID_W'(i);
                ma_d     = req_ma[i*MW +: MW];
                mb_d     = req_mb[i*MW +: MW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NST; s++) begin
                tag_q[s] <= '0;
            end
            ptr_q <= ID_W'(NREQ - 1);
            ma_q  <= '0;
            mb_q  <= '0;
        end else if (!hold) begin
            tag_q[0] <= tag_d;
            for (int s = 1; s < NST; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            ptr_q <= ptr_d;
            ma_q  <= ma_d;
            mb_q  <= mb_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        busy      = 1'b0;
        for (int s = 0; s < NST; s++) begin
            busy = busy | tag_q[s].v;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (tag_q[NST-1].v && !hold && (tag_q[NST-1].id == ID_W'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpmult_mant_arbiter.sv
// Directed bench for fpmult_mant_arbiter (NREQ=2, LAT=3) with a behavioural 3-stage core.
module tb_fpmult_mant_arbiter;

    localparam int NREQ = 2;
    localparam int MW   = 24;
    localparam int LAT  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               hold;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*MW-1:0] req_ma;
    logic [NREQ*MW-1:0] req_mb;
    logic [MW-1:0]      mul_ma;
    logic [MW-1:0]      mul_mb;
    logic               mul_en;
    logic [2*MW-1:0]    mul_mp;
    logic [NREQ-1:0]    rsp_valid;
    logic [2*MW-1:0]    rsp_mp;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;

    fpmult_mant_arbiter #(.NREQ(NREQ), .MW(MW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ma    (req_ma),
        .req_mb    (req_mb),
        .mul_ma    (mul_ma),
        .mul_mb    (mul_mb),
        .mul_en    (mul_en),
        .mul_mp    (mul_mp),
        .rsp_valid (rsp_valid),
        .rsp_mp    (rsp_mp),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier core: LAT register stages, clock-enabled by mul_en.
    logic [2*MW-1:0] core_p [LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            core_p[0] <= {{MW{1'b0}}, mul_ma} * {{MW{1'b0}}, mul_mb};
            for (int k = 1; k < LAT; k++) core_p[k] <= core_p[k-1];
        end
    end
    assign mul_mp = core_p[LAT-1];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = '0; req_ma = '0; req_mb = '0;
        cyc(); cyc();
        #1;
        chk("rst_ready", 48'(req_ready), 48'h0);
        chk("rst_rsp",   48'(rsp_valid), 48'h0);
        chk("rst_busy",  48'(busy),      48'h0);
        chk("rst_ma",    48'(mul_ma),    48'h0);
        cyc(); rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            cyc(); #1;
            chk("idle_outs", {45'h0, req_ready, busy}, 48'h0);
            chk("idle_rsp",  48'(rsp_valid), 48'h0);
        end

        // Single op from requester 0
        cyc(); req_valid = 2'b01; req_ma[23:0] = 24'h800000; req_mb[23:0] = 24'h800000;
        #1 chk("t1_ready", 48'(req_ready), 48'h1);
        cyc(); req_valid = 2'b00;
        #1 chk("t1_busy", 48'(busy), 48'h1);
        chk("t1_rsp_c1", 48'(rsp_valid), 48'h0);
        cyc(); #1 chk("t1_rsp_c2", 48'(rsp_valid), 48'h0);
        cyc(); #1 chk("t1_rsp_c3", 48'(rsp_valid), 48'h0);
        cyc(); #1 chk("t1_rsp_c4", 48'(rsp_valid), 48'h1);
        chk("t1_mp", rsp_mp, 48'h400000000000);
        cyc(); #1 chk("t1_drain", {46'h0, rsp_valid}, 48'h0);
        chk("t1_idle_busy", 48'(busy), 48'h0);

        // Reset with three ops in flight
        req_ma[23:0] = 24'hA00000; req_mb[23:0] = 24'hA00000;
        for (int c = 0; c < 3; c++) begin
            cyc(); req_valid = 2'b01;
            #1 chk("rs_ready", 48'(req_ready), 48'h1);
        end
        cyc(); req_valid = 2'b00;
        #1 chk("rs_busy_pre", 48'(busy), 48'h1);
        rst = 1'b1;
        #1 chk("rs_busy_now", 48'(busy), 48'h0);
        chk("rs_rsp_now", 48'(rsp_valid), 48'h0);
        chk("rs_ma_now", 48'(mul_ma), 48'h0);
        cyc(); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc(); #1 chk("rs_no_rsp", {46'h0, rsp_valid}, {47'h0, busy});
            chk("rs_busy_after", 48'(busy), 48'h0);
        end

        // Both requesters valid for four cycles
        req_ma = {24'hC00000, 24'hC00000};
        req_mb = {24'hC00000, 24'hA00000};
        cyc(); req_valid = 2'b11; #1 chk("t2_g0", 48'(req_ready), 48'h1);
        cyc(); #1 chk("t2_g1", 48'(req_ready), 48'h2);
        cyc(); #1 chk("t2_g2", 48'(req_ready), 48'h1);
        cyc(); #1 chk("t2_g3", 48'(req_ready), 48'h2);
        cyc(); req_valid = 2'b00;
        #1 chk("t2_rsp0", 48'(rsp_valid), 48'h1); chk("t2_mp0", rsp_mp, 48'h780000000000);
        cyc(); #1 chk("t2_rsp1", 48'(rsp_valid), 48'h2); chk("t2_mp1", rsp_mp, 48'h900000000000);
        cyc(); #1 chk("t2_rsp2", 48'(rsp_valid), 48'h1); chk("t2_mp2", rsp_mp, 48'h780000000000);
        cyc(); #1 chk("t2_rsp3", 48'(rsp_valid), 48'h2); chk("t2_mp3", rsp_mp, 48'h900000000000);
        cyc(); #1 chk("t2_end", 48'(rsp_valid), 48'h0);

        // Hold for 3 cycles with two ops in flight
        req_ma = {24'hC00000, 24'h800000};
        req_mb = {24'hC00000, 24'h800000};
        cyc(); req_valid = 2'b01; #1 chk("h_g0", 48'(req_ready), 48'h1);
        cyc(); req_valid = 2'b10; #1 chk("h_g1", 48'(req_ready), 48'h2);
        cyc(); req_valid = 2'b01; hold = 1'b1;
        #1 chk("h_ready", 48'(req_ready), 48'h0);
        chk("h_en", 48'(mul_en), 48'h0);
        chk("h_rsp2", 48'(rsp_valid), 48'h0);
        cyc(); req_valid = 2'b00; #1 chk("h_rsp3", 48'(rsp_valid), 48'h0);
        chk("h_busy", 48'(busy), 48'h1);
        cyc(); #1 chk("h_rsp4", 48'(rsp_valid), 48'h0);
        cyc(); hold = 1'b0; #1 chk("h_rsp5", 48'(rsp_valid), 48'h0);
        chk("h_en_back", 48'(mul_en), 48'h1);
        cyc(); #1 chk("h_rsp6", 48'(rsp_valid), 48'h0);
        cyc(); #1 chk("h_rsp7", 48'(rsp_valid), 48'h1); chk("h_mp7", rsp_mp, 48'h400000000000);
        cyc(); #1 chk("h_rsp8", 48'(rsp_valid), 48'h2); chk("h_mp8", rsp_mp, 48'h900000000000);
        cyc(); #1 chk("h_rsp9", 48'(rsp_valid), 48'h0);

        // Requester 1 continuous, requester 0 pulsing
        cyc(); req_valid = 2'b10; #1 chk("f0", 48'(req_ready), 48'h2);
        cyc(); req_valid = 2'b11; #1 chk("f1", 48'(req_ready), 48'h1);
        cyc(); req_valid = 2'b10; #1 chk("f2", 48'(req_ready), 48'h2);
        cyc(); req_valid = 2'b10; #1 chk("f3", 48'(req_ready), 48'h2);
        cyc(); req_valid = 2'b11; #1 chk("f4", 48'(req_ready), 48'h1);
        cyc(); req_valid = 2'b10; #1 chk("f5", 48'(req_ready), 48'h2);
        cyc(); req_valid = 2'b00;
        for (int c = 0; c < 6; c++) cyc();
        #1 chk("final_busy", 48'(busy), 48'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
